mio_bus_responder: RTL and testbench



---
 rtl/mio_pkg.sv | 40 ++++
 rtl/mio_ram.sv | 23 ++
 rtl/mio_bus_responder.sv | 145 ++++++++++++++
 tb/tb_mio_bus_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus responder: address map, FSM states and region decode.
// Optional timer region is enabled by defining MIO_TIMER_EN.
package mio_pkg;

  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] GPIO_ADDR  = 32'hE000_0000;
  localparam logic [31:0] TIMER_ADDR = 32'hF000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_GPIO,
    RGN_TIMER,
    RGN_NONE
  } region_e;

  // Decode works on word addresses; byte-lane bits never take part.
  function automatic region_e mio_decode(input logic [29:0] word_addr,
                                         input int unsigned addr_w);
    logic [29:0] ram_off;
    ram_off = word_addr - RAM_BASE[31:2];
    if ((ram_off >> addr_w) == '0) begin
      return RGN_RAM;
    end else if (word_addr == GPIO_ADDR[31:2]) begin
      return RGN_GPIO;
`ifdef MIO_TIMER_EN
    end else if (word_addr == TIMER_ADDR[31:2]) begin
      return RGN_TIMER;
`endif
    end else begin
      return RGN_NONE;
    end
  endfunction

endpackage

// File: rtl/mio_ram.sv
// Word RAM with synchronous write and asynchronous read; the parent registers the read data.
module mio_ram #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mio_bus_responder.sv
// MIO bus responder: decodes CPU requests to RAM / GPIO / timer with programmable wait states.
// Define MIO_TIMER_EN to include the free-running timer at TIMER_ADDR.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_out,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  output logic [31:0] gpio_out
);

  localparam logic [3:0] WaitInit = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  state_e      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [29:0] r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_data_in;
  logic [31:0] r_gpio;
`ifdef MIO_TIMER_EN
  logic [31:0] r_timer;
`endif

  logic [29:0] w_word_addr;
  region_e     w_region;
  logic [31:0] w_ram_rdata;
  logic [31:0] w_rd_data;
  logic        w_capture;
  logic        w_commit;
  logic        w_ram_we;
  logic        w_unused_lsb;

  assign w_unused_lsb = ^Addr_out[1:0];

  // With zero wait states the response is loaded on the capture edge, so read the live bus.
  assign w_word_addr = (r_state == IDLE) ? Addr_out[31:2] : r_addr;
  assign w_region    = mio_decode(w_word_addr, ADDR_W);
  assign w_commit    = (r_state == RESP) && r_we;
  assign w_ram_we    = w_commit && (w_region == RGN_RAM) && !reset;

  mio_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_word_addr[ADDR_W-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (CPU_MIO) begin
          w_capture = 1'b1;
          if (WAIT_STATES > 0) begin
            w_state_next = WAIT;
            w_cnt_next   = WaitInit;
          end else begin
            w_state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_rd_data = '0;
    case (w_region)
      RGN_RAM:   w_rd_data = w_ram_rdata;
      RGN_GPIO:  w_rd_data = r_gpio;
`ifdef MIO_TIMER_EN
      RGN_TIMER: w_rd_data = r_timer;
`endif
      default:   w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_data_in <= '0;
      r_gpio    <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_capture) begin
        r_addr  <= Addr_out[31:2];
        r_we    <= mem_w;
        r_wdata <= Data_out;
      end
      if (w_state_next == RESP) begin
        r_data_in <= w_rd_data;
      end
      if (w_commit && (w_region == RGN_GPIO)) begin
        r_gpio <= r_wdata;
      end
    end
  end

`ifdef MIO_TIMER_EN
  // A software load takes priority over the same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_commit && (w_region == RGN_TIMER)) begin
      r_timer <= r_wdata;
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end
`endif

  assign MIO_ready = (r_state == RESP);
  assign Data_in   = r_data_in;
  assign gpio_out  = r_gpio;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed plus randomized bench for mio_bus_responder against an address-map reference model.
module tb_mio_bus_responder;

  localparam int unsigned WS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        CPU_MIO;
  logic        mem_w;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic [31:0] Data_in;
  logic        MIO_ready;
  logic [31:0] gpio_out;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [31:0] m_ram [int];
  logic [31:0] m_gpio;

  mio_bus_responder #(
    .DEPTH       (1024),
    .ADDR_W      (10),
    .WAIT_STATES (WS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .CPU_MIO   (CPU_MIO),
    .mem_w     (mem_w),
    .Addr_out  (Addr_out),
    .Data_out  (Data_out),
    .Data_in   (Data_in),
    .MIO_ready (MIO_ready),
    .gpio_out  (gpio_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus transaction; bus inputs are scrambled after capture to prove they are ignored.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rd, output int resp_cyc);
    int lat;
    bit got;
    @(negedge clk);
    CPU_MIO  = 1'b1;
    mem_w    = we;
    Addr_out = addr;
    Data_out = wdata;
    lat = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (MIO_ready) got = 1;
      else lat++;
      if (i == 0) begin
        Addr_out = $urandom;
        Data_out = $urandom;
        mem_w    = ~we;
      end
    end
    chk("latency", 32'(lat), 32'(WS));
    rd       = Data_in;
    resp_cyc = cyc;
    CPU_MIO  = 1'b0;
    mem_w    = 1'b0;
    @(negedge clk);
    chk("ready_pulse", {31'd0, MIO_ready}, 32'd0);
    chk("data_hold", Data_in, rd);
  endtask

  logic [31:0] rd;
  int          rc, rw;

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    int c;
    txn(1'b1, addr, data, d, c);
    rw = c;
    if (addr < 32'h1000) m_ram[int'(addr[11:2])] = data;
    else if (addr[31:2] == 30'h3800_0000) m_gpio = data;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    int c;
    txn(1'b0, addr, 32'h0, d, c);
    rc = c;
    chk(tag, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_t;
    bit          got;
    reset    = 1'b1;
    CPU_MIO  = 1'b0;
    mem_w    = 1'b0;
    Addr_out = '0;
    Data_out = '0;
    m_gpio   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_ready", {31'd0, MIO_ready}, 32'd0);
    chk("rst_data_in", Data_in, 32'd0);
    chk("rst_gpio", gpio_out, 32'd0);

    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);

    wr(32'hE000_0000, 32'h0000_00A5);
    chk("gpio_out", gpio_out, 32'h0000_00A5);
    rd_chk("gpio_rd", 32'hE000_0000, 32'h0000_00A5);

    // Timer: value at read = load value + edges elapsed between load commit and read sampling.
    wr(32'hF000_0000, 32'hFFFF_FFFE);
    @(negedge clk);
    txn(1'b0, 32'hF000_0000, 32'h0, rd, rc);
`ifdef MIO_TIMER_EN
    exp_t = 32'hFFFF_FFFE + 32'(rc - rw - 2);
`else
    exp_t = 32'h0;
`endif
    chk("timer_rd", rd, exp_t);

    rd_chk("unmapped_rd", 32'h8000_0000, 32'h0);
    wr(32'h8000_0000, 32'h1234_5678);
    rd_chk("unmapped_gpio", 32'hE000_0000, m_gpio);
    rd_chk("unmapped_ram", 32'h0000_0010, 32'hDEAD_BEEF);
    wr(32'h0000_0000, 32'h0000_0000);
    wr(32'h0000_1000, 32'hCAFE_F00D);
    rd_chk("ram_end_alias", 32'h0000_0000, 32'h0);
    rd_chk("ram_end_rd", 32'h0000_1000, 32'h0);
    wr(32'h0000_0FFC, 32'h0BAD_CAFE);
    rd_chk("ram_top", 32'h0000_0FFF, 32'h0BAD_CAFE);

    // Reset while a write is waiting: no response and the write is lost.
    wr(32'h0000_0020, 32'h1111_1111);
    @(negedge clk);
    CPU_MIO  = 1'b1;
    mem_w    = 1'b1;
    Addr_out = 32'h0000_0020;
    Data_out = 32'h2222_2222;
    @(negedge clk);
    chk("wait_no_ready", {31'd0, MIO_ready}, 32'd0);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_wait_ready", {31'd0, MIO_ready}, 32'd0);
    end
    CPU_MIO = 1'b0;
    mem_w   = 1'b0;
    reset   = 1'b0;
    m_gpio  = '0;
    chk("rst_wait_gpio", gpio_out, 32'h0);
    rd_chk("rst_wait_ram", 32'h0000_0020, 32'h1111_1111);

    // Reset during the response cycle also discards the write.
    @(negedge clk);
    CPU_MIO  = 1'b1;
    mem_w    = 1'b1;
    Addr_out = 32'h0000_0020;
    Data_out = 32'h3333_3333;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (MIO_ready) got = 1;
    end
    chk("resp_seen", {31'd0, got}, 32'd1);
    reset   = 1'b1;
    CPU_MIO = 1'b0;
    mem_w   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rd_chk("rst_resp_ram", 32'h0000_0020, 32'h1111_1111);

    for (int n = 0; n < 60; n++) begin
      int unsigned kind;
      logic [31:0] a, d;
      logic        we;
      kind = $urandom_range(0, 9);
      we   = 1'($urandom_range(0, 1));
      d    = $urandom;
      if (kind < 6) begin
        if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 15)) << 2;
        else a = 32'($urandom_range(1008, 1023)) << 2;
      end else if (kind < 8) begin
        a = 32'hE000_0000;
      end else begin
        a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
      end
      a = a | 32'($urandom_range(0, 3));
      if (we) begin
        wr(a, d);
      end else if (kind >= 8) begin
        rd_chk("rnd_unmapped", a, 32'h0);
      end else if (kind >= 6) begin
        rd_chk("rnd_gpio", a, m_gpio);
      end else if (m_ram.exists(int'(a[11:2]))) begin
        rd_chk("rnd_ram", a, m_ram[int'(a[11:2])]);
      end
      chk("rnd_gpio_out", gpio_out, m_gpio);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
